// File: rtl/parallel_load1_if.sv
// Serial/parallel shift-register bus.
//   parallelload : load strobe, sampled on the rising clock edge
//   input1       : parallel word, WIDTH bits
//   sin          : serial input bit that back-fills the register while shifting
//   sout         : serial output bit, the outgoing end of the register
// The master modport drives load/data/serial-in and observes sout.
// The slave modport is the shift register itself.
interface parallel_load1_if #(
  parameter int WIDTH = 8
);
  logic             parallelload;
  logic [WIDTH-1:0] input1;
  logic             sin;
  logic             sout;

  modport master (
    output parallelload,
    output input1,
    output sin,
    input  sout
  );

  modport slave (
    input  parallelload,
    input  input1,
    input  sin,
    output sout
  );
endinterface

// File: rtl/parallel_load1.sv
// Parallel-in / serial-in, serial-out shift register used as a serialiser
// front-end. A word is loaded in one cycle and then clocked out one bit per
// edge, while sin back-fills the vacated end of the register.
// Ports:
//   clk : system clock, every state update happens on the rising edge
//   rst : synchronous active-high reset, clears the register
//   bus : parallel_load1_if slave (parallelload, input1, sin -> sout)
// Parameters:
//   WIDTH     : register and parallel word width, at least 2
//   MSB_FIRST : 1 shifts toward the MSB (sout = bit WIDTH-1, sin enters bit 0)
//               0 shifts toward the LSB (sout = bit 0, sin enters bit WIDTH-1)
// Priority on each edge: rst, then parallelload, then shift. There is no hold
// state, so the register shifts on every edge that is not a reset or a load.
module parallel_load1 #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst,
  parallel_load1_if.slave bus
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // One shift step in the configured direction. The bit that leaves the
  // register is the one sout shows now; sin takes the far end.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] cur,
    input logic             din
  );
    logic [WIDTH-1:0] nxt;
    if (MSB_FIRST != 0) begin
      nxt = {cur[WIDTH-2:0], din};
    end else begin
      nxt = {din, cur[WIDTH-1:1]};
    end
    return nxt;
  endfunction

  // Next-state selection. Reset is applied in the register process so it
  // overrides a simultaneous load.
  always_comb begin
    sr_d = shift_step(sr_q, bus.sin);
    if (bus.parallelload) begin
      sr_d = bus.input1;
    end
  end

  // Register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // sout comes straight from a flop, so nothing on the inputs reaches it
  // combinationally.
  if (MSB_FIRST != 0) begin : g_out_msb
    assign bus.sout = sr_q[WIDTH-1];
  end else begin : g_out_lsb
    assign bus.sout = sr_q[0];
  end

endmodule

// File: tb/tb_parallel_load1.sv
// Bench for parallel_load1: two instances (MSB_FIRST=1 and MSB_FIRST=0) get
// the same stimulus. Each stimulus cycle pushes the hand-computed sout values
// expected after that edge; a monitor pops and compares after every edge.
module tb_parallel_load1;

  localparam int W = 8;

  typedef struct {
    string tag;
    bit    chk1;
    bit    e1;
    bit    chk0;
    bit    e0;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sbq[$];
  int   checks;
  int   errors;

  parallel_load1_if #(.WIDTH(W)) if_m ();
  parallel_load1_if #(.WIDTH(W)) if_l ();

  parallel_load1 #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (if_m.slave)
  );

  parallel_load1 #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (if_l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs (at the falling edge) and queue the
  // sout values expected right after the following rising edge.
  task automatic step(
    input string      tag,
    input bit         r,
    input bit         pl,
    input logic [W-1:0] d,
    input bit         s,
    input bit         c1,
    input bit         e1,
    input bit         c0,
    input bit         e0
  );
    exp_t e;
    @(negedge clk);
    rst                = r;
    if_m.parallelload  = pl;
    if_l.parallelload  = pl;
    if_m.input1        = d;
    if_l.input1        = d;
    if_m.sin           = s;
    if_l.sin           = s;
    e.tag  = tag;
    e.chk1 = c1;
    e.e1   = e1;
    e.chk0 = c0;
    e.e0   = e0;
    sbq.push_back(e);
  endtask

  // Shift cycle with the same expected bit for both orders.
  task automatic shift_both(input string tag, input bit s, input bit e);
    step(tag, 1'b0, 1'b0, 8'h00, s, 1'b1, e, 1'b1, e);
  endtask

  // Monitor: after each rising edge compare both outputs against the
  // oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk1) begin
          checks++;
          if (if_m.sout !== e.e1) begin
            errors++;
            $display("FAIL %s msb_first: sout actual %b required %b", e.tag, if_m.sout, e.e1);
          end
        end
        if (e.chk0) begin
          checks++;
          if (if_l.sout !== e.e0) begin
            errors++;
            $display("FAIL %s lsb_first: sout actual %b required %b", e.tag, if_l.sout, e.e0);
          end
        end
      end
    end
  end

  initial begin
    bit seq_m[8];
    bit seq_l[8];
    bit fill[8];
    checks = 0;
    errors = 0;
    rst = 1'b0;
    if_m.parallelload = 1'b0;
    if_l.parallelload = 1'b0;
    if_m.input1 = '0;
    if_l.input1 = '0;
    if_m.sin = 1'b0;
    if_l.sin = 1'b0;

    // Reset overrides a simultaneous load of A5
    step("reset_over_load", 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("reset_over_load", 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Load FF, drain with sin=0: 1 on load edge + 7 shifts, then 0
    step("drain_load", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) shift_both("drain", 1'b0, (i <= 7));

    // Bit order with B4 = 1011_0100, sin=1
    seq_m = '{1, 0, 1, 1, 0, 1, 0, 0};
    seq_l = '{0, 0, 1, 0, 1, 1, 0, 1};
    step("order_load", 1'b0, 1'b1, 8'hB4, 1'b1, 1'b1, seq_m[0], 1'b1, seq_l[0]);
    for (int i = 1; i < 8; i++)
      step("order", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, seq_m[i], 1'b1, seq_l[i]);
    shift_both("order_backfill", 1'b1, 1'b1);
    shift_both("order_backfill", 1'b1, 1'b1);

    // Serial fill from reset: pattern 1,0,0,1,1,0,1,0 emerges 8 edges later
    step("fill_reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    fill = '{1, 0, 0, 1, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) shift_both("fill_zero", fill[i], 1'b0);
    shift_both("fill_first", fill[7], 1'b1);
    seq_m = '{0, 0, 1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) shift_both("fill_out", 1'b0, seq_m[i]);

    // Reload mid-shift: F0, 3 shifts, then 0F
    step("reload_f0", 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("reload_shift", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("reload_0f", 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    seq_m = '{0, 0, 0, 1, 1, 1, 1, 0};
    seq_l = '{1, 1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++)
      step("reload_out", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, seq_m[i], 1'b1, seq_l[i]);

    // Reset mid-shift: FF, 2 shifts, reset with sin=1, then shift in ones
    step("rmid_load", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    shift_both("rmid_shift", 1'b0, 1'b1);
    shift_both("rmid_shift", 1'b0, 1'b1);
    step("rmid_reset", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) shift_both("rmid_after", 1'b1, (i >= 8));

    // Held load: reloads every edge, sout stays at the first bit
    for (int i = 0; i < 3; i++)
      step("held_load", 1'b0, 1'b1, 8'hB4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("held_load_new", 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    shift_both("held_release", 1'b0, 1'b0);

    // Wait for the monitor to drain the scoreboard, bounded
    begin
      int budget;
      budget = 50;
      while (sbq.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: pending actual %0d required 0", sbq.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parallel_load1.md
Name: parallel_load1

Overview:
- 8-bit (parameterisable) parallel-in / serial-in, serial-out shift register.
- Loads a parallel word on command, or otherwise shifts one bit per clock, taking `sin` in and presenting the outgoing bit on `sout`.
- Used as a serialiser front-end: a word is loaded once and then clocked out bit-serially while the serial input back-fills the register.

Parameters:
- WIDTH, 8, register and parallel-input width; legal range ≥ 2.
- MSB_FIRST, 1, 1 = shift toward MSB (`sout` = bit WIDTH-1, `sin` enters bit 0); 0 = shift toward LSB (`sout` = bit 0, `sin` enters bit WIDTH-1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- parallelload  input  1  when high at a rising edge, the register loads `input1`.
- input1  input  WIDTH  parallel load data.
- sin  input  1  serial data shifted into the vacated end during shift cycles.
- sout  output  1  serial output; the outgoing end bit of the register.

Behaviour:
- Single internal register `sr[WIDTH-1:0]`. All updates are synchronous to the rising edge of `clk`. No asynchronous paths.
- Per-edge priority is rst > parallelload > shift:
  - rst=1: `sr` <= 0.
  - else parallelload=1: `sr` <= `input1` (the whole word; no shift this cycle).
  - else, MSB_FIRST=1: `sr` <= {sr[WIDTH-2:0], sin}.
  - else, MSB_FIRST=0: `sr` <= {sin, sr[WIDTH-1:1]}.
- Shifting is unconditional whenever neither rst nor parallelload is asserted. There is no enable and no idle hold.
- `sout` is driven directly from the register: `sr[WIDTH-1]` if MSB_FIRST=1, `sr[0]` if MSB_FIRST=0. No combinational path from any input to `sout`.
- Reset value: `sr` = 0, so `sout` = 0 from the edge at which rst is sampled high.
- Load latency, with a load at edge k:
  - After edge k, `sout` = input1[WIDTH-1] (MSB_FIRST=1) or input1[0] (MSB_FIRST=0).
  - Each subsequent non-load edge presents the next bit.
  - The last loaded bit appears after edge k+WIDTH-1.
- Back-fill: after WIDTH consecutive shift edges following a load, `sout` shows `sin` as sampled at the first shift edge. `sin` bits emerge WIDTH edges after being sampled.
- Held parallelload: `sr` reloads every edge and `sout` stays at the first bit of `input1`.
- Reset mid-shift: contents are discarded, `sr` = 0, and shifting resumes (zero-filled plus `sin`) on the first edge after rst falls.
- Before the first reset or load, `sr` is undefined. The bench applies rst first.
- Width rules: `input1` is exactly WIDTH bits; no truncation or extension.

Test Plan:
- Reset: rst=1 for 2 edges with input1=8'hA5, parallelload=1 → `sout`=0 and `sr`=0 (rst overrides load).
- Load/drain: load 8'hFF, then sin=0 for 10 edges → `sout`=1 for 8 edges after the load edge, then 0 thereafter.
- Bit order: load 8'hB4 (10110100), sin=1 → `sout` sequence 1,0,1,1,0,1,0,0, then 1,1,…; with MSB_FIRST=0 the sequence is 0,0,1,0,1,1,0,1, then 1,….
- Serial fill: after reset, sin pattern 1,0,0,1,1,0,1,0 on 8 edges → `sout` reproduces the pattern starting 8 edges after the first sin bit, i.e. the register holds 8'h9A for MSB_FIRST=1.
- Reload mid-shift: load 8'hF0, shift 3 edges, load 8'h0F → the next `sout` is 0, followed by 0,0,0,1,1,1,1.
- Reset mid-shift: load 8'hFF, shift 2 edges, rst=1 for 1 edge with sin=1 → `sout`=0 for 8 edges after reset release, then 1.
